// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types, field positions and opcode constants
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int FUNC_MSB   = 3;
  localparam int FUNC_LSB   = 0;

  localparam int PC_STEP = 2;

  localparam logic [3:0] OP_TYPE_A = 4'b1111;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1001;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with a one-entry skid buffer
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               skid_wr,
  input  logic               skid_pop,
  input  logic               drop,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_next
);

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  // Priority: clear > load > skid_pop > drop; otherwise everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (clear) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load) begin
        if_valid   <= 1'b1;
        if_instr   <= in_instr;
        if_pc      <= in_pc;
        if_pc_next <= in_pc + PC_W'(PC_STEP);
      end else if (skid_pop && skid_valid) begin
        if_valid   <= 1'b1;
        if_instr   <= skid_instr;
        if_pc      <= skid_pc;
        if_pc_next <= skid_pc + PC_W'(PC_STEP);
        skid_valid <= 1'b0;
      end else if (drop) begin
        if_valid <= 1'b0;
      end
      if (skid_wr) begin
        skid_valid <= 1'b1;
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, PC and imem req/ack handshake feeding IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter int          INSTR_W  = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_next,
  output logic [3:0]         opcode,
  output logic [3:0]         func,
  output logic               halted
);

  fetch_state_t    state, next_state;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] drain_addr, drain_addr_n;
  logic            clear, load, skid_wr, skid_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= PC_W'(RESET_PC);
      drain_addr <= '0;
    end else begin
      state      <= next_state;
      pc         <= pc_n;
      drain_addr <= drain_addr_n;
    end
  end

  // DRAIN keeps presenting the address of the abandoned request while pc already holds the target.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign halted    = (state == HALTED);

  always_comb begin
    next_state   = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    clear        = 1'b0;
    load         = 1'b0;
    skid_wr      = 1'b0;
    skid_pop     = 1'b0;
    if (state != HALTED && flush) begin
      clear = 1'b1;
      pc_n  = redirect_pc;
      if (imem_req && !imem_ack) begin
        next_state   = DRAIN;
        drain_addr_n = imem_addr;
      end else begin
        next_state = FETCH;
      end
    end else if (state != HALTED && halt) begin
      clear      = 1'b1;
      next_state = HALTED;
    end else begin
      case (state)
        IDLE:  next_state = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_n = pc + PC_W'(PC_STEP);
            if (if_valid && stall) begin
              skid_wr    = 1'b1;
              next_state = HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            skid_pop   = 1'b1;
            next_state = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) next_state = FETCH;
        end
        HALTED:  next_state = HALTED;
        default: next_state = IDLE;
      endcase
    end
  end

  fetch_stage_if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load       (load),
    .skid_wr    (skid_wr),
    .skid_pop   (skid_pop),
    .drop       (!stall),
    .in_instr   (imem_rdata),
    .in_pc      (pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_next (if_pc_next)
  );

  assign opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
  assign func   = if_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a grant-limited memory model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];

  int grant     = 0;
  int acks_done = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_next  (if_pc_next),
    .opcode      (opcode),
    .func        (func),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: memf = 16'hF047;
      16'h0002: memf = 16'h8123;
      16'h0004: memf = 16'hC456;
      default:  memf = {4'h2, a[11:0]};
    endcase
  endfunction

  // Memory acks only as many requests as the stimulus has granted.
  assign imem_ack   = imem_req && (acks_done < grant);
  assign imem_rdata = memf(imem_addr);
  always @(posedge clk) if (imem_ack) acks_done <= acks_done + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // Every instruction decode accepts (valid and not stalled) must match the next expected entry.
  always @(negedge clk) begin
    if (if_valid && !stall) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got %h at pc %h expected none", if_instr, if_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr",   {16'h0, if_instr},   {16'h0, e.instr});
        check("sb_pc",      {16'h0, if_pc},      {16'h0, e.pc});
        check("sb_pc_next", {16'h0, if_pc_next}, {16'h0, e.pc + 16'd2});
        check("sb_opcode",  {28'h0, opcode},     {28'h0, e.instr[15:12]});
        check("sb_func",    {28'h0, func},       {28'h0, e.instr[3:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = 16'h0;
    repeat (2) cyc();
    check("rst_req",    {31'h0, imem_req}, 32'h0);
    check("rst_valid",  {31'h0, if_valid}, 32'h0);
    check("rst_halted", {31'h0, halted},   32'h0);
    check("rst_instr",  {16'h0, if_instr}, 32'h0);
    check("rst_pcs",    {if_pc, if_pc_next}, 32'h0);
    check("rst_fields", {24'h0, opcode, func}, 32'h0);

    // Back-to-back single-cycle fetches
    push(16'hF047, 16'h0000); push(16'h8123, 16'h0002); push(16'hC456, 16'h0004);
    grant += 3;
    rst = 1'b0;
    cyc(); check("b2b_addr0", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
    cyc(); check("b2b_addr2", {16'h0, imem_addr}, 32'h0002);
    cyc(); check("b2b_addr4", {16'h0, imem_addr}, 32'h0004);
    cyc(); check("b2b_addr6", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0006});

    // Stall while a fetch returns: data lands in the skid buffer
    push(16'h2006, 16'h0006); push(16'h2008, 16'h0008);
    grant += 1;
    cyc();
    stall = 1'b1; grant += 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_req",   {31'h0, imem_req}, 32'h0);
      check("hold_ifid",  {if_instr, if_pc}, {16'h2006, 16'h0006});
      check("hold_valid", {31'h0, if_valid}, 32'h1);
    end
    stall = 1'b0;
    cyc();
    check("unstall_ifid", {if_instr, if_pc}, {16'h2008, 16'h0008});
    check("unstall_req",  {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h000A});

    // Flush with a request outstanding: drain then refetch at redirect
    flush = 1'b1; redirect_pc = 16'h0040;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("drain_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h000A});
      check("drain_valid", {31'h0, if_valid}, 32'h0);
      if (i == 0) cyc();
    end
    grant += 1;
    cyc();
    check("post_drain_valid", {31'h0, if_valid}, 32'h0);
    check("post_drain_addr",  {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0040});

    // Halt with a valid instruction in IF/ID
    push(16'h2040, 16'h0040);
    grant += 1;
    cyc();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("halt_state", {29'h0, halted, if_valid, imem_req}, {29'h0, 3'b100});
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_after_halt", {30'h0, halted, imem_req}, 32'h0);
    cyc();
    check("restart_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});

    // Ack in the flush cycle is discarded; PC wraps past 0xFFFE
    flush = 1'b1; redirect_pc = 16'hFFFE; grant += 1;
    cyc();
    flush = 1'b0;
    check("flush_ack_addr",  {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'hFFFE});
    check("flush_ack_valid", {31'h0, if_valid}, 32'h0);
    push(16'h2FFE, 16'hFFFE);
    grant += 1;
    cyc();
    check("wrap_addr",    {16'h0, imem_addr}, 32'h0000);
    check("wrap_pc",      {if_pc, if_pc_next}, {16'hFFFE, 16'h0000});

    // Flush and halt together: flush wins
    flush = 1'b1; halt = 1'b1; redirect_pc = 16'h0080;
    cyc();
    flush = 1'b0; halt = 1'b0;
    check("fh_halted", {31'h0, halted}, 32'h0);
    check("fh_drain",  {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
    grant += 1;
    cyc();
    check("fh_redirect", {15'h0, halted, imem_req, imem_addr}, {15'h0, 1'b0, 1'b1, 16'h0080});

    cyc();
    check("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of the opcode/func control decoder.
- Keeps the PC and runs a req/ack handshake to instruction memory. Presents the fetched 16-bit instruction with opcode[15:12] and func[3:0] split out for decode.
- Honours stall, branch-redirect flush and halt requests from later stages.

Parameters:
PC_W, 16, program-counter / instruction-address width
INSTR_W, 16, instruction width (fixed 16 for this ISA; opcode = [15:12], func = [3:0])
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, level, held until imem_ack
imem_addr  out  PC_W  fetch address, stable while imem_req=1
imem_ack  in  1  response valid; may arrive in the same cycle as req or any later cycle
imem_rdata  in  INSTR_W  instruction, valid when imem_ack=1
stall  in  1  decode cannot accept a new instruction this cycle
flush  in  1  redirect taken (branch resolved); discard in-flight work
redirect_pc  in  PC_W  new PC, sampled when flush=1
halt  in  1  decoded Halt from control; stop fetching
if_valid  out  1  IF/ID register holds a valid instruction
if_instr  out  INSTR_W  IF/ID instruction
if_pc  out  PC_W  address of if_instr
if_pc_next  out  PC_W  if_pc + 2, used for branch targets
opcode  out  4  if_instr[15:12]
func  out  4  if_instr[3:0]
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, all outputs 0. if_instr=0, so opcode=func=0. Skid buffer empty. Reset mid-transaction abandons the outstanding request; memory must tolerate a dropped req.
- PC advances by 2 per accepted instruction (byte-addressed memory). Wraps modulo 2^PC_W with no flag.
- States:
  - IDLE: one cycle after reset; imem_req=0; goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On ack with (!if_valid || !stall): load IF/ID next edge, if_valid=1, pc+=2, stay in FETCH. Back-to-back single-cycle fetch is possible.
    - On ack with (if_valid && stall): write rdata/pc into the one-entry skid buffer, pc+=2, go to HOLD.
  - HOLD: imem_req=0. When stall drops, move skid into IF/ID (if_valid=1), go to FETCH. No new fetch is issued while the skid is full.
  - DRAIN: entered on flush while a request is outstanding (req=1, no ack yet). Keeps req/addr until ack, discards rdata, then goes to FETCH with pc=redirect_pc (latched at flush).
  - HALTED: imem_req=0, halted=1, if_valid=0. Leaves only on rst.
- Stall with if_valid=1 and no incoming ack: IF/ID holds all values unchanged.
- Flush (any state except HALTED): next edge if_valid=0 and skid cleared. pc=redirect_pc, state=FETCH. If a req is outstanding without ack in the flush cycle, pc=redirect_pc and state=DRAIN. An ack in the flush cycle is discarded and the state goes to FETCH.
- Halt: next edge state=HALTED, if_valid=0, no further req. An outstanding request is abandoned.
- Priority within one cycle: rst > flush > halt > stall > ack.
- opcode/func are combinational slices of registered if_instr. No combinational path from imem_rdata to any output.

Decomposition:
- Shared package:
  - state encoding (IDLE, FETCH, HOLD, DRAIN, HALTED);
  - OPCODE_MSB/LSB and FUNC_MSB/LSB field positions;
  - PC_STEP=2;
  - opcode constants already used by the decoder (TYPE A=4'b1111, branch/load/store codes).
- One natural sub-module: if_id_reg, the IF/ID register plus one-entry skid buffer with load/hold/clear controls. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset, then ack in the same cycle as req, rdata 16'hF047/16'h8123/16'hC456 -> imem_addr 0,2,4 on consecutive cycles; opcode/func F/7, 8/3, C/6; if_pc 0,2,4.
- stall held 3 cycles when ack arrives for addr 4 -> instr at 2 stays in IF/ID; rdata captured in skid; req low; after stall drops, if_instr=addr-4 data, then next req at addr 6.
- ack delayed 3 cycles, flush with redirect_pc=16'h0040 on cycle 1 -> req and addr held until ack; rdata discarded; if_valid stays 0; next req addr=16'h0040.
- halt asserted with if_valid=1 -> next cycle halted=1, if_valid=0, imem_req=0 indefinitely; rst then restarts fetch at RESET_PC.
- PC=16'hFFFE accepted -> next addr 16'h0000, no error.
- flush and halt in the same cycle -> flush wins: pc=redirect_pc, halted stays 0.
